// File: rtl/display_pager.sv
// display_pager: multiplexes PAGES pages of nibbles onto DIGITS active-low
// 7-segment digits. Supports auto-rotation on a dwell timer, manual page
// selection, a page-advance button, per-page leading-zero blanking and
// whole-display blinking. All timing counts the shared clk_en tick.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   clk_en       single-cycle timebase tick (10 ms)
//   mode_auto    1: auto-rotate, 0: manual page_sel
//   page_sel     page shown in manual mode (out of range selects page 0)
//   next         debounced advance level; its rising edge acts in auto mode
//   page_data    nibbles, page p digit d at [(p*DIGITS+d)*4 +: 4]
//   blank_lz     per-page leading-zero blanking enable
//   blink        blink the whole display
//   seg          active-low GFEDCBA, digit d at [d*7 +: 7] (registered)
//   page         currently displayed page (registered)
//   page_change  one-cycle pulse whenever page changes (registered)
module display_pager #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned PAGES      = 4,
    parameter int unsigned DWELL      = 300,
    parameter int unsigned BLINK_HALF = 50,
    parameter int unsigned PW         = $clog2(PAGES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        mode_auto,
    input  logic [PW-1:0]               page_sel,
    input  logic                        next,
    input  logic [PAGES*DIGITS*4-1:0]   page_data,
    input  logic [PAGES-1:0]            blank_lz,
    input  logic                        blink,
    output logic [DIGITS*7-1:0]         seg,
    output logic [PW-1:0]               page,
    output logic                        page_change
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned NW = DIGITS * 4;

    logic [DW-1:0]       dwell_cnt, dwell_nxt;
    logic [BW-1:0]       blink_cnt, blink_nxt;
    logic                phase_on, phase_on_nxt;
    logic                next_d;
    logic                next_rise;
    logic [PW-1:0]       page_nxt, page_inc;
    logic [NW-1:0]       cur_data;
    logic                cur_lz;
    logic                lead;
    logic                blank_all;
    logic [3:0]          nib;
    logic [DIGITS*7-1:0] seg_nxt;

    // Active-high GFEDCBA pattern for one nibble
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Page index control: auto rotation, button advance, manual select
    always_comb begin
        page_nxt  = page;
        dwell_nxt = dwell_cnt;
        next_rise = next & ~next_d;
        page_inc  = (page == PW'(PAGES - 1)) ? '0 : page + PW'(1);
        if (mode_auto) begin
            // A button edge on the expiry tick still yields a single advance
            if (next_rise) begin
                page_nxt  = page_inc;
                dwell_nxt = '0;
            end else if (clk_en) begin
                if (dwell_cnt == DW'(DWELL - 1)) begin
                    page_nxt  = page_inc;
                    dwell_nxt = '0;
                end else begin
                    dwell_nxt = dwell_cnt + DW'(1);
                end
            end
        end else begin
            page_nxt  = ({1'b0, page_sel} < (PW + 1)'(PAGES)) ? page_sel : '0;
            dwell_nxt = '0;
        end
    end

    // Blink timebase; phase returns to on as soon as blink drops
    always_comb begin
        blink_nxt    = blink_cnt;
        phase_on_nxt = phase_on;
        if (!blink) begin
            blink_nxt    = '0;
            phase_on_nxt = 1'b1;
        end else if (clk_en) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_nxt    = '0;
                phase_on_nxt = ~phase_on;
            end else begin
                blink_nxt = blink_cnt + BW'(1);
            end
        end
    end

    // Select the displayed page's nibbles and its blanking enable
    always_comb begin
        cur_data = '0;
        cur_lz   = 1'b0;
        for (int p = 0; p < int'(PAGES); p++) begin
            if (page == PW'(p)) begin
                cur_data = page_data[p*NW +: NW];
                cur_lz   = blank_lz[p];
            end
        end
    end

    // Decode with leading-zero blanking scanned from the leftmost digit
    always_comb begin
        seg_nxt   = '1;
        nib       = '0;
        blank_all = blink & ~phase_on;
        lead      = cur_lz;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            nib = cur_data[d*4 +: 4];
            // Digit 0 always shows, so all-zero data reads as a single 0
            if (d == 0) begin
                lead = 1'b0;
            end else begin
                lead = lead & (nib == 4'h0);
            end
            seg_nxt[d*7 +: 7] = (blank_all || lead) ? 7'h7F : ~seg_decode(nib);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            page        <= '0;
            seg         <= '1;
            page_change <= 1'b0;
            dwell_cnt   <= '0;
            blink_cnt   <= '0;
            phase_on    <= 1'b1;
            next_d      <= 1'b0;
        end else begin
            page        <= page_nxt;
            seg         <= seg_nxt;
            page_change <= (page_nxt != page);
            dwell_cnt   <= dwell_nxt;
            blink_cnt   <= blink_nxt;
            phase_on    <= phase_on_nxt;
            next_d      <= next;
        end
    end

endmodule
